channel_deskew: RTL and testbench
=================================

# channel_deskew

Receive-side lane aligner for the DVI path. Takes three word-aligned 10-bit TMDS symbol streams whose arrival times differ by up to MAX_SKEW beats and measures each lane's offset at the blanking→active-video boundary. It then applies per-lane variable delays so that all lanes leave the block beat-aligned. It is the read-side counterpart of the transmit-side fixed-latency delay alignment. It sits between the per-lane word aligners and the TMDS decoders.

## Interface
- WIDTH, 10, symbol width per lane
- N_LANES, 3, number of lanes
- MAX_SKEW, 4, largest correctable inter-lane offset in beats
- MIN_RUN, 8, consecutive control tokens required before an edge qualifies
- MISMATCH_LIMIT, 2, consecutive misaligned edges in LOCKED before relock
- clk_i  input  1  pixel clock
- rst_i  input  1  reset; asynchronous, active-high
- data_i  input  N_LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- valid_i  input  1  beat enable; when low, nothing advances (counters, delay lines, FSM frozen)
- data_o  output  N_LANES*WIDTH  aligned symbols, registered
- valid_o  output  1  valid_i registered one cycle
- locked_o  output  1  delays measured and confirmed

## Operation
- Control token: one of 10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011.
- Per lane, a run counter saturates at MIN_RUN. It increments on a token beat and clears on a non-token beat.
- Edge on lane k: a non-token beat while its run counter == MIN_RUN. Runs shorter than MIN_RUN never produce an edge.
- Offset counter is $clog2(MAX_SKEW+1) bits wide. Per-lane offsets o_k use the same width.
- FSM states:
  - SEARCH
    - Edge on ≥1 lane: those lanes capture o_k=0, counter←1, go to MEASURE.
    - Edge on all lanes in the same beat: delays all 0, go directly to LOCKED.
  - MEASURE (one valid beat per count)
    - Lanes whose first edge arrives capture o_k=counter. Repeat edges on captured lanes are ignored.
    - All lanes captured: d_k = max(o) − o_k, delays loaded, go to LOCKED.
    - Counter == MAX_SKEW with a lane still missing after that beat: go to SEARCH, delays unchanged.
  - LOCKED
    - Edge detection also runs on the delayed lanes, with the same run/edge rule.
    - Edge on some but not all delayed lanes in one beat = mismatch. Edge on all lanes = match, which clears the mismatch count.
    - Mismatch count reaching MISMATCH_LIMIT: go to SEARCH and deassert locked_o. Delays are retained until the next successful measurement.
- locked_o is high exactly in LOCKED.

## Timing
- Reset values: data_o=0, valid_o=0, locked_o=0, all d_k=0, state SEARCH, all counters and delay contents 0.
- Lane k latency = d_k valid beats + 1 output register cycle. Fixed while delays are stable.
- Delays update and locked_o rises on the same clock edge that enters LOCKED.
- For d_k beats after a delay change, data_o carries stale lane contents. Consumers qualify with locked_o.
- locked_o falls on the clock edge that enters SEARCH.
- valid_i low beats are invisible to measurement: offsets are counted in valid beats only.
- rst_i assertion mid-operation forces all reset values immediately, independent of clk_i.

## Configuration
- CHANNEL_DESKEW_STATS_EN
  - Defined: adds output lane_delay_o (N_LANES*$clog2(MAX_SKEW+1), current d_k). Also adds output relock_cnt_o (8 bits, counts LOCKED→SEARCH transitions, saturates at 255, reset 0).
  - Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package tmds_pkg:
  - the four control-token constants
  - function is_ctrl_token
  - deskew FSM state enum typedef
- Sub-module lane_delay (one instance per lane):
  - shift register of MAX_SKEW entries with a select input 0..MAX_SKEW
  - 0 = bypass
  - advances only when valid_i is high
  - feeds the shared output register

## Test plan
1. **Zero skew.** Identical lanes, 10-token blanking then data, repeated → locked_o=1 after the first edge; delays 0,0,0; data_o equals data_i one cycle later.
2. **Static skew.** Lane1 lags by 2 and lane2 lags by 3 (MAX_SKEW=4) → d=3,1,0; delayed edges coincide; lane0 latency 4 cycles; no mismatches over 5 lines.
3. **Skew too large.** Lane2 lags by 5 → MEASURE times out each line; locked_o stays 0; delays remain 0.
4. **Skew change.** Locked with lane1 delay 1, then lane1 lag shifts by +1 → locked_o drops after the 2nd mismatched edge; relocks on the next qualifying line with d_1 updated. relock_cnt_o=1 when the macro is defined.
5. **Gapped input.** valid_i low for 3 cycles inside MEASURE, with the skews of test 2 → same delays 3,1,0; outputs frozen during the gap.
6. **Reset mid-measure.** rst_i pulsed while in MEASURE → locked_o, valid_o, data_o go to 0 immediately; a clean relock follows on the next line. A 7-token run (<MIN_RUN) never triggers an edge.

Source files
------------

// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_pkg
//  Description : Shared TMDS definitions: the four DVI control-token symbols,
//                a token classifier and the deskew FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam logic [9:0] C_CTRL_TOKEN_0 = 10'b1101010100;
    localparam logic [9:0] C_CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [9:0] C_CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [9:0] C_CTRL_TOKEN_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } deskew_state_t;

    function automatic logic is_ctrl_token(input logic [9:0] sym);
        return (sym == C_CTRL_TOKEN_0) || (sym == C_CTRL_TOKEN_1) ||
               (sym == C_CTRL_TOKEN_2) || (sym == C_CTRL_TOKEN_3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_delay.sv
`default_nettype none
// ============================================================================
//  Module      : lane_delay
//  Description : Variable delay line for one lane. Holds the last MAX_SKEW
//                accepted symbols; sel = 0 passes the input straight through,
//                sel = j returns the symbol accepted j beats ago.
//  Ports       : clk, rst (async, active-high), advance (beat enable),
//                din (symbol in), sel (delay 0..MAX_SKEW), dout (delayed)
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_delay #(
    parameter int WIDTH    = 10,
    parameter int MAX_SKEW = 4,
    parameter int SEL_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] dout
);

    logic [MAX_SKEW-1:0][WIDTH-1:0] r_taps;

    // The taps keep shifting regardless of sel, so a delay change only
    // re-selects history rather than refilling the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taps <= '0;
        end else if (advance) begin
            r_taps[0] <= din;
            for (int i = 1; i < MAX_SKEW; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    always_comb begin
        dout = din;
        for (int i = 0; i < MAX_SKEW; i++) begin
            if (sel == SEL_W'(i + 1)) begin
                dout = r_taps[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/channel_deskew.sv
`default_nettype none
// ============================================================================
//  Module      : channel_deskew
//  Description : Receive-side TMDS lane aligner. Measures the per-lane offset
//                of the blanking->active edge, then delays the early lanes
//                so all lanes leave beat-aligned. Confirms alignment on the
//                delayed lanes and relocks after repeated misaligned edges.
//  Ports       : clk_i, rst_i (async, active-high), data_i/valid_i (lane k at
//                bits [k*WIDTH +: WIDTH]), data_o/valid_o (registered),
//                locked_o (high while in LOCKED)
//  Options     : CHANNEL_DESKEW_STATS_EN adds lane_delay_o (current delays)
//                and relock_cnt_o (saturating LOCKED->SEARCH count)
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_deskew
    import tmds_pkg::*;
#(
    parameter int WIDTH          = 10,
    parameter int N_LANES        = 3,
    parameter int MAX_SKEW       = 4,
    parameter int MIN_RUN        = 8,
    parameter int MISMATCH_LIMIT = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_LANES*WIDTH-1:0] data_i,
    input  logic                     valid_i,
    output logic [N_LANES*WIDTH-1:0] data_o,
    output logic                     valid_o,
    output logic                     locked_o
`ifdef CHANNEL_DESKEW_STATS_EN
    ,
    output logic [N_LANES*$clog2(MAX_SKEW+1)-1:0] lane_delay_o,
    output logic [7:0]                            relock_cnt_o
`endif
);

    localparam int C_OFS_W = $clog2(MAX_SKEW + 1);
    localparam int C_RUN_W = $clog2(MIN_RUN + 1);
    localparam int C_MIS_W = $clog2(MISMATCH_LIMIT + 1);

    localparam logic [C_RUN_W-1:0] C_RUN_SAT  = C_RUN_W'(MIN_RUN);
    localparam logic [C_OFS_W-1:0] C_CNT_LAST = C_OFS_W'(MAX_SKEW);
    localparam logic [C_MIS_W-1:0] C_MIS_LAST = C_MIS_W'(MISMATCH_LIMIT - 1);

    logic [N_LANES-1:0][WIDTH-1:0]   w_raw;
    logic [N_LANES-1:0][WIDTH-1:0]   w_dly;
    logic [N_LANES-1:0]              w_edge_raw;
    logic [N_LANES-1:0]              w_edge_dly;

    deskew_state_t                   r_state,   w_state_nxt;
    logic [C_OFS_W-1:0]              r_cnt,     w_cnt_nxt;
    logic [N_LANES-1:0]              r_capt,    w_capt_nxt;
    logic [N_LANES-1:0][C_OFS_W-1:0] r_ofs,     w_ofs_nxt;
    logic [N_LANES-1:0][C_OFS_W-1:0] r_sel,     w_sel_nxt;
    logic [C_MIS_W-1:0]              r_mis,     w_mis_nxt;
    logic [C_OFS_W-1:0]              w_max;

    // ------------------------------------------------------------------
    // Per-lane delay line and edge detectors. Edges are detected both on
    // the raw lane (for measurement) and on the delayed lane (to confirm
    // alignment while locked).
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < N_LANES; k++) begin : g_lane
            logic [C_RUN_W-1:0] r_run_raw;
            logic [C_RUN_W-1:0] r_run_dly;
            logic               w_tok_raw;
            logic               w_tok_dly;

            assign w_raw[k] = data_i[k*WIDTH +: WIDTH];

            lane_delay #(
                .WIDTH    (WIDTH),
                .MAX_SKEW (MAX_SKEW),
                .SEL_W    (C_OFS_W)
            ) u_delay (
                .clk     (clk_i),
                .rst     (rst_i),
                .advance (valid_i),
                .din     (w_raw[k]),
                .sel     (r_sel[k]),
                .dout    (w_dly[k])
            );

            assign w_tok_raw = is_ctrl_token(w_raw[k]);
            assign w_tok_dly = is_ctrl_token(w_dly[k]);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_run_raw <= '0;
                    r_run_dly <= '0;
                end else if (valid_i) begin
                    if (!w_tok_raw)
                        r_run_raw <= '0;
                    else if (r_run_raw != C_RUN_SAT)
                        r_run_raw <= r_run_raw + 1'b1;

                    if (!w_tok_dly)
                        r_run_dly <= '0;
                    else if (r_run_dly != C_RUN_SAT)
                        r_run_dly <= r_run_dly + 1'b1;
                end
            end

            assign w_edge_raw[k] = valid_i & ~w_tok_raw & (r_run_raw == C_RUN_SAT);
            assign w_edge_dly[k] = valid_i & ~w_tok_dly & (r_run_dly == C_RUN_SAT);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Deskew FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_SEARCH;
            r_cnt   <= '0;
            r_capt  <= '0;
            r_ofs   <= '0;
            r_sel   <= '0;
            r_mis   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_capt  <= w_capt_nxt;
            r_ofs   <= w_ofs_nxt;
            r_sel   <= w_sel_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Deskew FSM: next state. Everything is gated by valid_i so idle
    // beats are invisible to the offset count.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capt_nxt  = r_capt;
        w_ofs_nxt   = r_ofs;
        w_sel_nxt   = r_sel;
        w_mis_nxt   = r_mis;
        w_max       = '0;

        if (valid_i) begin
            case (r_state)
                ST_SEARCH: begin
                    if (|w_edge_raw) begin
                        w_capt_nxt = w_edge_raw;
                        w_ofs_nxt  = '0;
                        w_cnt_nxt  = C_OFS_W'(1);
                        if (&w_edge_raw) begin
                            w_sel_nxt   = '0;
                            w_mis_nxt   = '0;
                            w_state_nxt = ST_LOCKED;
                        end else begin
                            w_state_nxt = ST_MEASURE;
                        end
                    end
                end

                ST_MEASURE: begin
                    // Only the first edge of each lane is recorded.
                    for (int i = 0; i < N_LANES; i++) begin
                        if (w_edge_raw[i] && !r_capt[i]) begin
                            w_capt_nxt[i] = 1'b1;
                            w_ofs_nxt[i]  = r_cnt;
                        end
                    end
                    if (&w_capt_nxt) begin
                        // Latest lane gets no delay; earlier lanes wait for it.
                        for (int i = 0; i < N_LANES; i++) begin
                            if (w_ofs_nxt[i] > w_max)
                                w_max = w_ofs_nxt[i];
                        end
                        for (int i = 0; i < N_LANES; i++) begin
                            w_sel_nxt[i] = w_max - w_ofs_nxt[i];
                        end
                        w_mis_nxt   = '0;
                        w_state_nxt = ST_LOCKED;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = ST_SEARCH;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (&w_edge_dly) begin
                        w_mis_nxt = '0;
                    end else if (|w_edge_dly) begin
                        if (r_mis == C_MIS_LAST) begin
                            w_mis_nxt   = '0;
                            w_state_nxt = ST_SEARCH;
                        end else begin
                            w_mis_nxt = r_mis + 1'b1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shared output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i)
                data_o <= w_dly;
        end
    end

    assign locked_o = (r_state == ST_LOCKED);

`ifdef CHANNEL_DESKEW_STATS_EN
    logic [7:0] r_relock_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_relock_cnt <= '0;
        end else if ((r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH) &&
                     (r_relock_cnt != 8'hFF)) begin
            r_relock_cnt <= r_relock_cnt + 8'd1;
        end
    end

    assign relock_cnt_o = r_relock_cnt;
    assign lane_delay_o = r_sel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_channel_deskew.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_channel_deskew
//  Description : Directed self-checking bench for channel_deskew. Lane k
//                carries a common line pattern (10 control tokens, 6 data
//                symbols) delayed by lag[k] valid beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_deskew;

    localparam int PERIOD = 16;
    localparam int NTOK   = 10;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [29:0] data_i;
    logic        valid_i;
    logic [29:0] data_o;
    logic        valid_o;
    logic        locked_o;
`ifdef CHANNEL_DESKEW_STATS_EN
    logic [8:0]  lane_delay_o;
    logic [7:0]  relock_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int lag [3];
    int vbeat;
    int short_line;

    always #5 clk = ~clk;

    channel_deskew #(
        .WIDTH          (10),
        .N_LANES        (3),
        .MAX_SKEW       (4),
        .MIN_RUN        (8),
        .MISMATCH_LIMIT (2)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .locked_o (locked_o)
`ifdef CHANNEL_DESKEW_STATS_EN
        ,
        .lane_delay_o (lane_delay_o),
        .relock_cnt_o (relock_cnt_o)
`endif
    );

    // Common line pattern. Line index short_line carries only 7 tokens.
    function automatic logic [9:0] base_word(input int m);
        int mm, pos, line, ntok;
        logic [9:0] w;
        mm   = m + 64;
        pos  = mm % PERIOD;
        line = mm / PERIOD;
        ntok = (line == short_line) ? 7 : NTOK;
        if (pos < ntok) begin
            case (pos % 4)
                0:       w = 10'b1101010100;
                1:       w = 10'b0010101011;
                2:       w = 10'b0101010100;
                default: w = 10'b1010101011;
            endcase
        end else begin
            w = 10'h1F0 | 10'(pos);
        end
        return w;
    endfunction

    // Expected data_o after valid beat n with lane delays d0..d2.
    function automatic logic [29:0] exp_out(input int n, input int d0, input int d1, input int d2);
        logic [29:0] r;
        r[9:0]   = base_word(n - d0 - lag[0]);
        r[19:10] = base_word(n - d1 - lag[1]);
        r[29:20] = base_word(n - d2 - lag[2]);
        return r;
    endfunction

    // Drive one cycle (valid or idle) and return #1 after the capturing edge.
    task automatic beat(input bit v);
        if (v) begin
            data_i[9:0]   = base_word(vbeat - lag[0]);
            data_i[19:10] = base_word(vbeat - lag[1]);
            data_i[29:20] = base_word(vbeat - lag[2]);
        end else begin
            data_i = {3{10'h3FF}};
        end
        valid_i = v;
        @(posedge clk);
        #1;
        if (v) vbeat++;
    endtask

    task automatic do_reset;
        valid_i = 1'b0;
        data_i  = '0;
        rst_i   = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        vbeat = 0;
    endtask

    task automatic test_reset;
        lag = '{0, 0, 0};
        short_line = -1;
        valid_i = 1'b0;
        data_i  = '0;
        rst_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data_o !== 30'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", data_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b want 0", locked_o); end
`ifdef CHANNEL_DESKEW_STATS_EN
        n_cmp++; if (lane_delay_o !== 9'd0) begin n_bad++; $display("FAIL reset_delays got %h want 0", lane_delay_o); end
        n_cmp++; if (relock_cnt_o !== 8'd0) begin n_bad++; $display("FAIL reset_relock got %0d want 0", relock_cnt_o); end
`endif
        rst_i = 1'b0;
        vbeat = 0;
    endtask

    task automatic test_zero_skew;
        lag = '{0, 0, 0};
        short_line = -1;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            beat(1'b1);
            n_cmp++; if (locked_o !== (n >= 10)) begin n_bad++; $display("FAIL zero_lock n=%0d got %b want %b", n, locked_o, (n >= 10)); end
            n_cmp++; if (data_o !== exp_out(n, 0, 0, 0)) begin n_bad++; $display("FAIL zero_data n=%0d got %h want %h", n, data_o, exp_out(n, 0, 0, 0)); end
            n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL zero_valid n=%0d got %b want 1", n, valid_o); end
        end
`ifdef CHANNEL_DESKEW_STATS_EN
        n_cmp++; if (lane_delay_o !== 9'd0) begin n_bad++; $display("FAIL zero_delays got %h want 0", lane_delay_o); end
`endif
    endtask

    task automatic test_static_skew;
        lag = '{0, 2, 3};
        short_line = -1;
        do_reset();
        for (int n = 0; n < 94; n++) begin
            beat(1'b1);
            n_cmp++; if (locked_o !== (n >= 13)) begin n_bad++; $display("FAIL static_lock n=%0d got %b want %b", n, locked_o, (n >= 13)); end
            if (n >= 14) begin
                n_cmp++; if (data_o !== exp_out(n, 3, 1, 0)) begin n_bad++; $display("FAIL static_data n=%0d got %h want %h", n, data_o, exp_out(n, 3, 1, 0)); end
            end else begin
                n_cmp++; if (data_o !== exp_out(n, 0, 0, 0)) begin n_bad++; $display("FAIL static_pre n=%0d got %h want %h", n, data_o, exp_out(n, 0, 0, 0)); end
            end
        end
`ifdef CHANNEL_DESKEW_STATS_EN
        n_cmp++; if (lane_delay_o !== {3'd0, 3'd1, 3'd3}) begin n_bad++; $display("FAIL static_delays got %h want %h", lane_delay_o, {3'd0, 3'd1, 3'd3}); end
`endif
    endtask

    task automatic test_skew_too_large;
        lag = '{0, 0, 5};
        short_line = -1;
        do_reset();
        for (int n = 0; n < 96; n++) begin
            beat(1'b1);
            n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL large_lock n=%0d got %b want 0", n, locked_o); end
            n_cmp++; if (data_o !== exp_out(n, 0, 0, 0)) begin n_bad++; $display("FAIL large_data n=%0d got %h want %h", n, data_o, exp_out(n, 0, 0, 0)); end
        end
`ifdef CHANNEL_DESKEW_STATS_EN
        n_cmp++; if (lane_delay_o !== 9'd0) begin n_bad++; $display("FAIL large_delays got %h want 0", lane_delay_o); end
`endif
    endtask

    task automatic test_skew_change;
        bit exp_lock;
        logic [29:0] exp_d;
        lag = '{1, 0, 1};
        short_line = -1;
        do_reset();
        for (int n = 0; n < 100; n++) begin
            if (n == 48) lag[1] = 1;
            beat(1'b1);
            exp_lock = ((n >= 11) && (n <= 59)) || (n >= 75);
            n_cmp++; if (locked_o !== exp_lock) begin n_bad++; $display("FAIL change_lock n=%0d got %b want %b", n, locked_o, exp_lock); end
            if (n != 48) begin
                if ((n >= 12) && (n <= 75)) exp_d = exp_out(n, 0, 1, 0);
                else                        exp_d = exp_out(n, 0, 0, 0);
                n_cmp++; if (data_o !== exp_d) begin n_bad++; $display("FAIL change_data n=%0d got %h want %h", n, data_o, exp_d); end
            end
        end
`ifdef CHANNEL_DESKEW_STATS_EN
        n_cmp++; if (relock_cnt_o !== 8'd1) begin n_bad++; $display("FAIL change_relock got %0d want 1", relock_cnt_o); end
        n_cmp++; if (lane_delay_o !== 9'd0) begin n_bad++; $display("FAIL change_delays got %h want 0", lane_delay_o); end
`endif
    endtask

    task automatic test_gapped;
        lag = '{0, 2, 3};
        short_line = -1;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            beat(1'b1);
            n_cmp++; if (data_o !== exp_out(n, 0, 0, 0)) begin n_bad++; $display("FAIL gap_pre n=%0d got %h want %h", n, data_o, exp_out(n, 0, 0, 0)); end
        end
        for (int g = 0; g < 3; g++) begin
            beat(1'b0);
            n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL gap_valid g=%0d got %b want 0", g, valid_o); end
            n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL gap_lock g=%0d got %b want 0", g, locked_o); end
            n_cmp++; if (data_o !== exp_out(11, 0, 0, 0)) begin n_bad++; $display("FAIL gap_frozen g=%0d got %h want %h", g, data_o, exp_out(11, 0, 0, 0)); end
        end
        for (int n = 12; n < 48; n++) begin
            beat(1'b1);
            n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL gap_post_valid n=%0d got %b want 1", n, valid_o); end
            n_cmp++; if (locked_o !== (n >= 13)) begin n_bad++; $display("FAIL gap_lock n=%0d got %b want %b", n, locked_o, (n >= 13)); end
            if (n >= 14) begin
                n_cmp++; if (data_o !== exp_out(n, 3, 1, 0)) begin n_bad++; $display("FAIL gap_data n=%0d got %h want %h", n, data_o, exp_out(n, 3, 1, 0)); end
            end
        end
`ifdef CHANNEL_DESKEW_STATS_EN
        n_cmp++; if (lane_delay_o !== {3'd0, 3'd1, 3'd3}) begin n_bad++; $display("FAIL gap_delays got %h want %h", lane_delay_o, {3'd0, 3'd1, 3'd3}); end
`endif
    endtask

    task automatic test_reset_mid_measure;
        lag = '{0, 2, 3};
        short_line = -1;
        do_reset();
        for (int n = 0; n < 12; n++) beat(1'b1);
        // Mid-cycle assertion: outputs must clear before the next clock edge.
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++; if (data_o !== 30'd0) begin n_bad++; $display("FAIL midrst_data got %h want 0", data_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", valid_o); end
        n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL midrst_locked got %b want 0", locked_o); end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        vbeat = 0;
        // First line after reset has only 7 tokens and must not qualify.
        short_line = 4;
        for (int n = 0; n < 50; n++) begin
            beat(1'b1);
            n_cmp++; if (locked_o !== (n >= 29)) begin n_bad++; $display("FAIL relock_lock n=%0d got %b want %b", n, locked_o, (n >= 29)); end
            if (n >= 30) begin
                n_cmp++; if (data_o !== exp_out(n, 3, 1, 0)) begin n_bad++; $display("FAIL relock_data n=%0d got %h want %h", n, data_o, exp_out(n, 3, 1, 0)); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        vbeat   = 0;
        test_reset();
        test_zero_skew();
        test_static_skew();
        test_skew_too_large();
        test_skew_change();
        test_gapped();
        test_reset_mid_measure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
